seq_divider_8: RTL

- Sequential unsigned restoring divider. It is the shift-left counterpart of the lab5 shift-right add-shift multiplier datapath.
- One quotient bit is produced per clock. The partial remainder and quotient pair shifts left; each cycle does a trial subtraction.
- Sits beside the multiplier in the lab arithmetic unit and uses the same Run/Done handshake style, driven by switches and a button.

---
 rtl/seq_divider_8.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_divider_8.sv
// Sequential unsigned restoring divider: one quotient bit per clock, remainder/quotient pair shifts left.
// Latency: Done rises on the 9th edge counting the start edge (WIDTH+1); on a zero divisor it rises on the start edge itself.
// Backpressure: Run is level-sensitive; DONE holds while Run stays high, so Run must drop between divisions.
module seq_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH:0]   r_r;      // partial remainder, top bit is the borrow guard
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_count;
  logic             r_dz;

  // The guard bit of R is always 0 between iterations (R < D), so {R, Q msb}
  // is the shifted value s already zero-extended to WIDTH+2 bits.
  logic [WIDTH+1:0] w_sx;
  logic [WIDTH+1:0] w_t;
  logic             w_borrow;
  logic             w_last;

  assign w_sx     = {r_r, r_q[WIDTH-1]};
  assign w_t      = w_sx - {2'b00, r_d};
  assign w_borrow = w_t[WIDTH+1];
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (Run) w_next_state = (Divisor == '0) ? S_DONE : S_COMPUTE;
      S_COMPUTE: if (w_last) w_next_state = S_DONE;
      S_DONE:    if (!Run) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture on start, one restoring step per COMPUTE edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_count <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Run) begin
            r_d     <= Divisor;
            r_count <= '0;
            r_dz    <= (Divisor == '0);
            if (Divisor == '0) begin
              // Zero divisor: report all-ones quotient and the dividend as remainder.
              r_q <= '1;
              r_r <= {1'b0, Dividend};
            end else begin
              r_q <= Dividend;
              r_r <= '0;
            end
          end
        end
        S_COMPUTE: begin
          if (w_borrow) r_r <= w_sx[WIDTH:0];
          else          r_r <= w_t[WIDTH:0];
          r_q     <= {r_q[WIDTH-2:0], ~w_borrow};
          r_count <= r_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state and result registers.
  always_comb begin
    Quotient    = r_q;
    Remainder   = r_r[WIDTH-1:0];
    Busy        = (r_state == S_COMPUTE);
    Done        = (r_state == S_DONE);
    Div_By_Zero = (r_state == S_DONE) && r_dz;
  end

endmodule
